// File: rtl/instr_assembler_pkg.sv
// Retro16 ISA definitions shared by the assembler and the core decoder:
// class codes, condition codes, opcode prefixes, immediate limits, error codes.
package instr_assembler_pkg;

  typedef enum logic [2:0] {
    CLS_SHIFT   = 3'd0,
    CLS_ALU_RR  = 3'd1,
    CLS_ALU_IMM = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_NOP     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_BADCOND  = 2'd2,
    ERR_BADCLASS = 2'd3
  } err_code_e;

  // Branch conditions; encodings with cond[1:0]=11 are reserved.
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_LT = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_Z  = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_GE = 3'b110;

  // Opcode prefixes (MSB-aligned in the instruction word).
  localparam logic [4:0] OP_SHIFT   = 5'b00000;
  localparam logic [4:0] OP_ALU_RR  = 5'b00001;
  localparam logic [2:0] OP_ALU_IMM = 3'b001;
  localparam logic [2:0] OP_LOAD    = 3'b010;
  localparam logic [2:0] OP_STORE   = 3'b011;
  localparam logic       OP_BRANCH  = 1'b1;

  // Signed immediate limits per field width.
  localparam int IMM5_MIN  = -16;
  localparam int IMM5_MAX  = 15;
  localparam int IMM7_MIN  = -64;
  localparam int IMM7_MAX  = 63;
  localparam int OFF12_MIN = -2048;
  localparam int OFF12_MAX = 2047;

  // True when the 16-bit two's-complement value lies in [lo, hi].
  function automatic logic fits(input logic [15:0] v, input int lo, input int hi);
    int s;
    s = int'($signed(v));
    return (s >= lo) && (s <= hi);
  endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Loader-side request/org handshake plus program-RAM write port.
interface instr_assembler_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              org_valid;
  logic [ADDR_W-1:0] org_addr;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_class;
  logic [2:0]        req_cond;
  logic [1:0]        req_alu_op;
  logic [2:0]        req_rd;
  logic [2:0]        req_ra;
  logic [2:0]        req_rb;
  logic [15:0]       req_imm;
  logic              req_abs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] wr_ptr;

  modport master (
    output org_valid, org_addr, req_valid, req_class, req_cond, req_alu_op,
           req_rd, req_ra, req_rb, req_imm, req_abs, mem_ack,
    input  req_ready, mem_we, mem_addr, mem_wdata, err, err_code, wr_ptr
  );

  modport slave (
    input  org_valid, org_addr, req_valid, req_class, req_cond, req_alu_op,
           req_rd, req_ra, req_rb, req_imm, req_abs, mem_ack,
    output req_ready, mem_we, mem_addr, mem_wdata, err, err_code, wr_ptr
  );
endinterface

// File: rtl/instr_assembler_pack.sv
// Combinational field packing, immediate range check and error classification.
module instr_pack
  import instr_assembler_pkg::*;
(
  input  logic [2:0]  i_class,
  input  logic [2:0]  i_cond,
  input  logic [1:0]  i_alu_op,
  input  logic [2:0]  i_rd,
  input  logic [2:0]  i_ra,
  input  logic [2:0]  i_rb,
  input  logic [15:0] i_imm,
  input  logic        i_abs,
  input  logic [15:0] i_ptr,
  output logic [15:0] o_word,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  logic [15:0] w_off;
  logic        w_range_ok;
  logic        w_bad_cond;
  logic        w_bad_class;

  // Pack the word for the requested class and flag any rejection reason.
  always_comb begin
    w_off       = i_abs ? (i_imm - i_ptr) : i_imm;
    o_word      = '0;
    w_range_ok  = 1'b1;
    w_bad_cond  = 1'b0;
    w_bad_class = 1'b0;
    case (instr_class_e'(i_class))
      CLS_SHIFT: begin
        o_word     = {OP_SHIFT, i_rd, i_ra, i_imm[4:0]};
        w_range_ok = fits(i_imm, IMM5_MIN, IMM5_MAX);
      end
      CLS_ALU_RR: o_word = {OP_ALU_RR, i_alu_op, i_rd, i_ra, i_rb};
      CLS_ALU_IMM: begin
        o_word     = {OP_ALU_IMM, i_alu_op, i_rd, i_ra, i_imm[4:0]};
        w_range_ok = fits(i_imm, IMM5_MIN, IMM5_MAX);
      end
      CLS_LOAD: begin
        o_word     = {OP_LOAD, i_rd, i_ra, i_imm[6:0]};
        w_range_ok = fits(i_imm, IMM7_MIN, IMM7_MAX);
      end
      CLS_STORE: begin
        o_word     = {OP_STORE, i_rd, i_ra, i_imm[6:0]};
        w_range_ok = fits(i_imm, IMM7_MIN, IMM7_MAX);
      end
      CLS_BRANCH: begin
        o_word     = {OP_BRANCH, i_cond, w_off[11:0]};
        w_range_ok = fits(w_off, OFF12_MIN, OFF12_MAX);
        w_bad_cond = (i_cond[1:0] == 2'b11);
      end
      CLS_NOP:  o_word = '0;
      default:  w_bad_class = 1'b1;
    endcase
  end

  // Priority: BADCLASS over BADCOND over RANGE.
  always_comb begin
    if (w_bad_class)     o_err_code = ERR_BADCLASS;
    else if (w_bad_cond) o_err_code = ERR_BADCOND;
    else if (!w_range_ok) o_err_code = ERR_RANGE;
    else                 o_err_code = ERR_NONE;
    o_err = w_bad_class | w_bad_cond | ~w_range_ok;
  end

endmodule

// File: rtl/instr_assembler.sv
// Retro16 instruction assembler: accepts field-level requests, encodes them
// and writes the words to program RAM at an auto-incrementing pointer.
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_assembler_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE, S_ERROR} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic              r_err;
  err_code_e         r_err_code;
  err_code_e         r_pend_code;
  logic [2:0]        r_class;
  logic [2:0]        r_cond;
  logic [1:0]        r_alu_op;
  logic [2:0]        r_rd;
  logic [2:0]        r_ra;
  logic [2:0]        r_rb;
  logic [15:0]       r_imm;
  logic              r_abs;

  logic [15:0]       w_word;
  logic              w_err;
  logic [1:0]        w_err_code;
  logic [15:0]       w_ptr16;

  assign w_ptr16 = 16'(r_wr_ptr);

  instr_pack u_pack (
    .i_class    (r_class),
    .i_cond     (r_cond),
    .i_alu_op   (r_alu_op),
    .i_rd       (r_rd),
    .i_ra       (r_ra),
    .i_rb       (r_rb),
    .i_imm      (r_imm),
    .i_abs      (r_abs),
    .i_ptr      (w_ptr16),
    .o_word     (w_word),
    .o_err      (w_err),
    .o_err_code (w_err_code)
  );

  // org_valid wins over a request, so ready drops while it is asserted.
  assign bus.req_ready = rst_n && (r_state == S_IDLE) && !bus.org_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
  assign bus.wr_ptr    = r_wr_ptr;

  // Control FSM: latch request, encode, then write to RAM or report the error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_pend_code <= ERR_NONE;
      r_class     <= '0;
      r_cond      <= '0;
      r_alu_op    <= '0;
      r_rd        <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_imm       <= '0;
      r_abs       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.org_valid) begin
            r_wr_ptr <= bus.org_addr;
          end else if (bus.req_valid) begin
            r_class  <= bus.req_class;
            r_cond   <= bus.req_cond;
            r_alu_op <= bus.req_alu_op;
            r_rd     <= bus.req_rd;
            r_ra     <= bus.req_ra;
            r_rb     <= bus.req_rb;
            r_imm    <= bus.req_imm;
            r_abs    <= bus.req_abs;
            r_state  <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (w_err) begin
            r_pend_code <= err_code_e'(w_err_code);
            r_state     <= S_ERROR;
          end else begin
            r_mem_wdata <= w_word;
            r_state     <= S_WRITE;
          end
        end
        // First WRITE cycle raises the strobe; ack only counts once it is high.
        S_WRITE: begin
          if (!r_mem_we) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_wr_ptr;
          end else if (bus.mem_ack) begin
            r_mem_we <= 1'b0;
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            r_state  <= S_IDLE;
          end
        end
        S_ERROR: begin
          r_err      <= 1'b1;
          r_err_code <= r_pend_code;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler with hand-computed expected words.
module tb_instr_assembler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  instr_assembler_if #(.ADDR_W(16)) bus ();

  instr_assembler #(.ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] cls, input logic [2:0] cond, input logic [1:0] alu,
                      input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [15:0] imm, input logic abs_t);
    bit done;
    done = 0;
    @(negedge clk);
    bus.req_class = cls; bus.req_cond = cond; bus.req_alu_op = alu;
    bus.req_rd = rd; bus.req_ra = ra; bus.req_rb = rb;
    bus.req_imm = imm; bus.req_abs = abs_t;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1 bus.req_valid = 1'b0;
    chk("accept", 32'(done), 32'd1);
  endtask

  task automatic set_org(input logic [15:0] a);
    @(negedge clk);
    bus.org_valid = 1'b1;
    bus.org_addr  = a;
    bus.req_class = 3'd6;
    bus.req_valid = 1'b1;
    #1 chk("org_ready_low", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 bus.org_valid = 1'b0;
    bus.req_valid = 1'b0;
    chk("org_ptr", 32'(bus.wr_ptr), 32'(a));
  endtask

  task automatic expect_write(input string tag, input logic [15:0] addr,
                              input logic [15:0] data, input int delay);
    bit seen;
    logic [15:0] nxt;
    seen = 0;
    nxt = addr + 16'd1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_we) seen = 1;
    end
    chk({tag, "_we"}, 32'(seen), 32'd1);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(data));
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk({tag, "_hold_we"}, 32'(bus.mem_we), 32'd1);
      chk({tag, "_hold_addr"}, 32'(bus.mem_addr), 32'(addr));
      chk({tag, "_hold_wdata"}, 32'(bus.mem_wdata), 32'(data));
      chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.mem_ack = 1'b1;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    chk({tag, "_we_drop"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_ptr"}, 32'(bus.wr_ptr), 32'(nxt));
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code, input logic [15:0] ptr);
    bit seen, we_seen;
    seen = 0;
    we_seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_we) we_seen = 1;
      if (bus.err) seen = 1;
    end
    chk({tag, "_err"}, 32'(seen), 32'd1);
    chk({tag, "_code"}, 32'(bus.err_code), 32'(code));
    chk({tag, "_no_we"}, 32'(we_seen), 32'd0);
    @(negedge clk);
    chk({tag, "_err_pulse"}, 32'(bus.err), 32'd0);
    chk({tag, "_code_held"}, 32'(bus.err_code), 32'(code));
    chk({tag, "_ptr"}, 32'(bus.wr_ptr), 32'(ptr));
  endtask

  initial begin
    bus.org_valid = 0; bus.org_addr = '0; bus.req_valid = 0;
    bus.req_class = '0; bus.req_cond = '0; bus.req_alu_op = '0;
    bus.req_rd = '0; bus.req_ra = '0; bus.req_rb = '0;
    bus.req_imm = '0; bus.req_abs = 0; bus.mem_ack = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_code", 32'(bus.err_code), 32'd0);
    chk("rst_ptr", 32'(bus.wr_ptr), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("idle_ready", 32'(bus.req_ready), 32'd1);

    // ALU_RR alu_op=01 rd=3 ra=1 rb=2 -> 0x0ACA, with latency check
    send(3'd1, 3'd0, 2'b01, 3'd3, 3'd1, 3'd2, 16'd0, 1'b0);
    @(negedge clk) chk("lat_n1_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk) chk("lat_n2_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk) chk("lat_n3_we", 32'(bus.mem_we), 32'd1);
    expect_write("alurr", 16'h0000, 16'h0ACA, 0);

    // Branch absolute target 0x0010 from 0x0014 -> offset -4
    set_org(16'h0014);
    send(3'd5, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0010, 1'b1);
    expect_write("br_abs", 16'h0014, 16'h8FFC, 0);

    // LOAD rd=2 ra=5 imm=-1
    send(3'd3, 3'd0, 2'b00, 3'd2, 3'd5, 3'd0, 16'hFFFF, 1'b0);
    expect_write("load", 16'h0015, 16'h4AFF, 0);

    // ALU_IMM imm=16 out of range
    send(3'd2, 3'd0, 2'b00, 3'd1, 3'd1, 3'd0, 16'd16, 1'b0);
    expect_err("aluimm_rng", 2'd1, 16'h0016);

    // ALU_IMM alu_op=00 rd=1 ra=1 imm=-3
    send(3'd2, 3'd0, 2'b00, 3'd1, 3'd1, 3'd0, 16'hFFFD, 1'b0);
    expect_write("aluimm", 16'h0016, 16'h213D, 0);

    // STORE rd=7 ra=0 imm=63 (upper limit), ack delayed 3 cycles
    send(3'd4, 3'd0, 2'b00, 3'd7, 3'd0, 3'd0, 16'd63, 1'b0);
    expect_write("store_slow", 16'h0017, 16'h7C3F, 3);

    // Reserved branch condition
    send(3'd5, 3'b011, 2'b00, 3'd0, 3'd0, 3'd0, 16'd0, 1'b0);
    expect_err("badcond", 2'd2, 16'h0018);

    // Class 7 with reserved cond: BADCLASS has priority
    send(3'd7, 3'b011, 2'b00, 3'd0, 3'd0, 3'd0, 16'd0, 1'b0);
    expect_err("badclass", 2'd3, 16'h0018);

    // Branch relative offset 2048 just outside the 12-bit range
    send(3'd5, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 16'd2048, 1'b0);
    expect_err("br_rng", 2'd1, 16'h0018);

    // NOP at 0xFFFF, pointer wraps to 0
    set_org(16'hFFFF);
    send(3'd6, 3'd0, 2'b00, 3'd0, 3'd0, 3'd0, 16'd0, 1'b0);
    expect_write("nop_wrap", 16'hFFFF, 16'h0000, 0);

    // Stray ack in IDLE is ignored
    @(negedge clk) bus.mem_ack = 1'b1;
    @(negedge clk) bus.mem_ack = 1'b0;
    chk("stray_ack_ptr", 32'(bus.wr_ptr), 32'd0);
    chk("stray_ack_we", 32'(bus.mem_we), 32'd0);

    // Reset during WRITE abandons the write
    set_org(16'h0100);
    send(3'd1, 3'd0, 2'b01, 3'd3, 3'd1, 3'd2, 16'd0, 1'b0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (bus.mem_we) seen = 1;
      end
      chk("midrst_we_before", 32'(seen), 32'd1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_ptr", 32'(bus.wr_ptr), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("midrst_idle", 32'(bus.req_ready), 32'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Sequential encoder for the Retro16 16-bit ISA: the inverse of the core instruction decoder.
- Accepts one field-level instruction request per handshake, packs it into a 16-bit word, and range-checks the immediates.
- Converts absolute branch targets to PC-relative offsets and writes the word into program RAM at an auto-incrementing address.
- Sits between the debug/monitor loader and the program-RAM write port.

Parameters:
ADDR_W, 16, program RAM address width; the write pointer wraps modulo 2^ADDR_W.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  reset, synchronous, active-low
org_valid  in  1  load the write pointer from org_addr; honoured only in IDLE
org_addr  in  ADDR_W  new write-pointer value
req_valid  in  1  instruction request valid
req_ready  out  1  high only in IDLE; a transfer occurs when req_valid and req_ready are both high
req_class  in  3  0=SHIFT 1=ALU_RR 2=ALU_IMM 3=LOAD 4=STORE 5=BRANCH 6=NOP 7=illegal
req_cond  in  3  branch condition: 000 always, 001 LT, 010 GT, 100 Z, 101 LE, 110 GE
req_alu_op  in  2  ALU operation field
req_rd  in  3  destination register; the data register for STORE
req_ra  in  3  first source register; the base register for LOAD/STORE
req_rb  in  3  second source register (ALU_RR only)
req_imm  in  16  signed immediate, or the branch target when req_abs=1
req_abs  in  1  BRANCH only: req_imm is an absolute target address
mem_we  out  1  RAM write strobe; held until mem_ack
mem_addr  out  ADDR_W  RAM write address
mem_wdata  out  16  encoded instruction word
mem_ack  in  1  RAM accepted the write this cycle
err  out  1  one-cycle pulse: request rejected
err_code  out  2  1=RANGE 2=BADCOND 3=BADCLASS; held until the next err pulse
wr_ptr  out  ADDR_W  current write pointer

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - wr_ptr=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, err_code=0.
  - req_ready=0 while rst_n is low.
  - Reset taken mid-WRITE abandons the write; mem_we is low in the cycle after the reset edge.
- FSM states: IDLE -> ENCODE -> (WRITE | ERROR) -> IDLE.
- IDLE:
  - req_ready=1.
  - org_valid loads wr_ptr; org_valid takes priority over a request in the same cycle (req_ready=0 that cycle).
  - An accepted request is latched, then the FSM moves to ENCODE.
- ENCODE (one cycle): pack fields, range-check, and register mem_wdata. Encodings:
  - SHIFT: [15:11]=00000, [10:8]=rd, [7:5]=ra, [4:0]=imm; imm must be in -16..15.
  - ALU_RR: [15:11]=00001, [10:9]=alu_op, [8:6]=rd, [5:3]=ra, [2:0]=rb.
  - ALU_IMM: [15:13]=001, [12:11]=alu_op, [10:8]=rd, [7:5]=ra, [4:0]=imm; imm must be in -16..15.
  - LOAD: [15:13]=010, [12:10]=rd, [9:7]=ra, [6:0]=imm; imm must be in -64..63.
  - STORE: [15:13]=011, [12:10]=rd (data), [9:7]=ra (base), [6:0]=imm; imm must be in -64..63.
  - BRANCH: [15]=1, [14:12]=cond, [11:0]=off.
    - off = req_imm when req_abs=0.
    - off = req_imm - wr_ptr (16-bit two's complement) when req_abs=1.
    - off must be in -2048..2047.
    - cond 011 or 111 gives BADCOND.
  - NOP: word 0x0000.
  - Class 7 gives BADCLASS.
- Check priority: BADCLASS > BADCOND > RANGE.
- On any failure: go to ERROR. No write is issued and wr_ptr is unchanged.
- WRITE:
  - mem_we=1, mem_addr=wr_ptr, mem_wdata stable until mem_ack.
  - On mem_ack: mem_we=0 the next cycle, wr_ptr+1 (wrapping 2^ADDR_W-1 -> 0), return to IDLE.
  - mem_ack seen outside WRITE is ignored.
- ERROR: err=1 for exactly one cycle, err_code updated, then IDLE.
- Latency:
  - Acceptance at edge N.
  - mem_we is high after edge N+2.
  - The earliest next acceptance is at the edge after the mem_ack edge.
  - Error path: err is high after edge N+2.

Decomposition:
- Shared include isa_defs.vh holds:
  - class codes;
  - condition codes;
  - opcode prefixes (SHIFT 00000, ALU_RR 00001, ALU_IMM 001, LOAD 010, STORE 011, BRANCH 1);
  - field bit positions;
  - immediate limits;
  - err_code values.
- The core decoder also uses isa_defs.vh.
- One sub-module, instr_pack: purely combinational field packing, range check and error classification. The FSM, pointer and handshake stay in instr_assembler.

Test Plan:
- After reset, ALU_RR alu_op=01 rd=3 ra=1 rb=2, mem_ack on the first WRITE cycle -> mem_addr=0x0000, mem_wdata=0x0ACA, wr_ptr=1.
- org_addr=0x0014; BRANCH cond=000 req_abs=1 target=0x0010 -> mem_wdata=0x8FFC at 0x0014. LOAD rd=2 ra=5 imm=-1 -> 0x4AFF at 0x0015.
- ALU_IMM imm=16 -> err pulse, err_code=1, mem_we never high, wr_ptr unchanged. ALU_IMM alu_op=00 rd=1 ra=1 imm=-3 -> 0x213D.
- BRANCH cond=011 -> err_code=2. Class 7 with cond=011 -> err_code=3 (priority). NOP at wr_ptr=0xFFFF with ADDR_W=16 -> 0x0000 written, wr_ptr wraps to 0.
- mem_ack delayed 3 cycles -> mem_we, mem_addr and mem_wdata stable throughout, req_ready=0. rst_n low mid-WRITE -> mem_we=0 and wr_ptr=0 after the reset edge.
